// File: rtl/simmem_pkg.sv
// Shared types and default timing for the simmem delay calculator.
// Bank state fields are sized by the package default row and counter widths.
package simmem_pkg;

  localparam int unsigned TCl             = 4;
  localparam int unsigned TRcd            = 5;
  localparam int unsigned TRp             = 5;
  localparam int unsigned DefRowWidth     = 8;
  localparam int unsigned DefCounterWidth = 8;

  typedef enum logic [1:0] {
    RowHit,
    RowClosed,
    RowConflict
  } row_state_e;

  typedef struct packed {
    logic                       open_valid;
    logic [DefRowWidth-1:0]     open_row;
    logic [DefCounterWidth-1:0] busy;
  } bank_state_t;

endpackage

// File: rtl/simmem_bank_state.sv
// One DRAM bank: open-row tracking plus a busy countdown.
// A load always wins over the decrement in the same cycle.
module simmem_bank_state
  import simmem_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_en,
  input  logic [DefRowWidth-1:0]     load_row,
  input  logic [DefCounterWidth-1:0] load_busy,
  output bank_state_t                state
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= '0;
    end else if (load_en) begin
      state.open_valid <= 1'b1;
      state.open_row   <= load_row;
      state.busy       <= load_busy;
    end else if (state.busy != '0) begin
      state.busy <= state.busy - 1'b1;
    end
  end

endmodule

// File: rtl/simmem_delay_calc.sv
// Computes each request's release delay from a per-bank open-row/busy model.
// Result is issued as {id, delay} on a registered valid/ready output.
module simmem_delay_calc #(
  parameter int unsigned IDWidth      = 8,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned CounterWidth = simmem_pkg::DefCounterWidth,
  parameter int unsigned NumBanks     = 4,
  parameter int unsigned BankLsb      = 10,
  parameter int unsigned RowLsb       = 12,
  parameter int unsigned RowWidth     = simmem_pkg::DefRowWidth,
  parameter int unsigned TCl          = simmem_pkg::TCl,
  parameter int unsigned TRcd         = simmem_pkg::TRcd,
  parameter int unsigned TRp          = simmem_pkg::TRp
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IDWidth-1:0]      req_id_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  output logic                    delay_valid_o,
  input  logic                    delay_ready_i,
  output logic [IDWidth-1:0]      delay_id_o,
  output logic [CounterWidth-1:0] delay_o
);
  import simmem_pkg::*;

  localparam int unsigned BankWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned RawWidth  = CounterWidth + 2;
  localparam logic [RawWidth-1:0] DelayMax = RawWidth'((2 ** CounterWidth) - 1);

  logic                    acc;
  logic [BankWidth-1:0]    bank;
  logic [RowWidth-1:0]     row;
  logic [NumBanks-1:0]     bank_sel;
  bank_state_t             bank_q [NumBanks];
  bank_state_t             sel_state;
  row_state_e              row_state;
  logic [RawWidth-1:0]     raw;
  logic [CounterWidth-1:0] delay;
  logic                    unused_addr;

  // Valid/ready: a transfer happens on each edge where valid & ready are both high;
  // ready never depends on valid, and the output holds while valid & ~ready.
  assign req_ready_o = ~delay_valid_o | delay_ready_i;
  assign acc         = req_valid_i & req_ready_o;

  assign bank        = req_addr_i[BankLsb +: BankWidth];
  assign row         = req_addr_i[RowLsb +: RowWidth];
  assign unused_addr = ^req_addr_i;

  always_comb begin
    bank_sel  = '0;
    sel_state = '0;
    for (int i = 0; i < NumBanks; i++) begin
      bank_sel[i] = (bank == BankWidth'(i));
      sel_state   = bank_state_t'(sel_state | (bank_q[i] & {$bits(bank_state_t){bank_sel[i]}}));
    end
  end

  always_comb begin
    if (!sel_state.open_valid) begin
      row_state = RowClosed;
    end else if (sel_state.open_row == DefRowWidth'(row)) begin
      row_state = RowHit;
    end else begin
      row_state = RowConflict;
    end

    raw = RawWidth'(sel_state.busy);
    case (row_state)
      RowHit:    raw = raw + RawWidth'(TCl);
      RowClosed: raw = raw + RawWidth'(TRcd + TCl);
      default:   raw = raw + RawWidth'(TRp + TRcd + TCl);
    endcase

    delay = (raw > DelayMax) ? DelayMax[CounterWidth-1:0] : raw[CounterWidth-1:0];
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    simmem_bank_state u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_en   (acc & bank_sel[b]),
      .load_row  (DefRowWidth'(row)),
      .load_busy (DefCounterWidth'(delay)),
      .state     (bank_q[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      delay_valid_o <= 1'b0;
      delay_id_o    <= '0;
      delay_o       <= '0;
    end else if (acc) begin
      delay_valid_o <= 1'b1;
      delay_id_o    <= req_id_i;
      delay_o       <= delay;
    end else if (delay_ready_i) begin
      delay_valid_o <= 1'b0;
    end
  end

endmodule
